// File: rtl/ospfb_src_sched.sv
// Source-side scheduler for an oversampled PFB. It gates a valid/ready
// stream so that DEC_FAC new samples go through per FFT_LEN-slot frame, then
// stalls for the remaining FFT_LEN-DEC_FAC slots. It also tracks the phase
// rotation and counts completed frames.
//
// Handshake: a transfer on either side happens on a clock edge where valid
// and ready are both high. Valid never waits on ready. The datapath is purely
// combinational, so the source and sink handshake in the same cycle.
module ospfb_src_sched #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FFT_LEN = 64,
  parameter int unsigned DEC_FAC = 48,
  parameter int unsigned START   = 47,
  localparam int unsigned SW     = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [SW-1:0]    slot,
  output logic [SW-1:0]    shift,
  output logic [31:0]      frame_cnt,
  output logic             busy
);

  if (DEC_FAC < 1 || DEC_FAC > FFT_LEN || START >= FFT_LEN) begin : g_bad_params
    $error("ospfb_src_sched: illegal parameters (need 1<=DEC_FAC<=FFT_LEN, START<FFT_LEN)");
  end

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [SW-1:0] SLOT_LAST = SW'(FFT_LEN - 1);
  localparam logic [SW-1:0] D_LAST    = SW'(DEC_FAC - 1);
  localparam logic [SW-1:0] START_S   = SW'(START);

  state_t        state, state_nx;
  logic [SW-1:0] slot_nx, slot_inc, shift_nx, shift_wrapped;
  logic [SW:0]   shift_sum;
  logic [31:0]   frame_cnt_nx;
  logic          adv;
  logic          run;

  // Slots below DEC_FAC pass samples. Slots at or above it are stall slots.
  function automatic state_t mode_of(input logic [SW-1:0] s);
    return (32'(s) < DEC_FAC) ? RUN : PAUSE;
  endfunction

  assign slot_inc      = slot + SW'(1);
  assign shift_sum     = {1'b0, shift} + (SW+1)'(DEC_FAC);
  assign shift_wrapped = (32'(shift_sum) >= FFT_LEN) ?
                         SW'(shift_sum - (SW+1)'(FFT_LEN)) : shift_sum[SW-1:0];

  // Next state: IDLE waits for en. RUN advances on handshake and PAUSE
  // every cycle. en is looked at again only on the frame wrap.
  always_comb begin
    state_nx     = state;
    slot_nx      = slot;
    shift_nx     = shift;
    frame_cnt_nx = frame_cnt;
    adv          = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          slot_nx  = START_S;
          state_nx = mode_of(START_S);
        end
      end
      RUN:     adv = s_axis_tvalid & m_axis_tready;
      PAUSE:   adv = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (adv) begin
      if (slot == SLOT_LAST) begin
        frame_cnt_nx = frame_cnt + 32'd1;
        shift_nx     = shift_wrapped;
        if (en) begin
          slot_nx  = '0;
          state_nx = RUN;
        end else begin
          slot_nx  = START_S;
          state_nx = IDLE;
        end
      end else begin
        slot_nx  = slot_inc;
        state_nx = mode_of(slot_inc);
      end
    end
  end

  // State, slot, phase and frame counter registers. Reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= START_S;
      shift     <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nx;
      slot      <= slot_nx;
      shift     <= shift_nx;
      frame_cnt <= frame_cnt_nx;
    end
  end

  assign run           = (state == RUN);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid & run;
  assign s_axis_tready = m_axis_tready & run;
  assign m_axis_tlast  = run && (slot == D_LAST);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ospfb_src_sched.sv
// Bench for ospfb_src_sched. Instance A uses M=64, D=48, START=47 and runs
// the directed scenarios. Instance B uses D=M=16, START=0 and runs
// pass-through for the whole time. A frame-level model of each instance is
// compared against the DUT outputs on every cycle.
module tb_ospfb_src_sched;

  logic        clk = 1'b0;
  logic        rst_a, en_a, vld_a, rdy_a, rst_b, en_b, vld_b, rdy_b;
  logic [15:0] sdata_a, sdata_b;
  logic        s_tready_a, m_tvalid_a, m_tlast_a, busy_a;
  logic        s_tready_b, m_tvalid_b, m_tlast_b, busy_b;
  logic [15:0] m_tdata_a, m_tdata_b;
  logic [5:0]  slot_a, shift_a;
  logic [3:0]  slot_b, shift_b;
  logic [31:0] frame_cnt_a, frame_cnt_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] exp_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  ospfb_src_sched #(.WIDTH(16), .FFT_LEN(64), .DEC_FAC(48), .START(47)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a),
    .s_axis_tdata(sdata_a), .s_axis_tvalid(vld_a), .s_axis_tready(s_tready_a),
    .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(rdy_a),
    .m_axis_tlast(m_tlast_a), .slot(slot_a), .shift(shift_a),
    .frame_cnt(frame_cnt_a), .busy(busy_a));

  ospfb_src_sched #(.WIDTH(16), .FFT_LEN(16), .DEC_FAC(16), .START(0)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b),
    .s_axis_tdata(sdata_b), .s_axis_tvalid(vld_b), .s_axis_tready(s_tready_b),
    .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(rdy_b),
    .m_axis_tlast(m_tlast_b), .slot(slot_b), .shift(shift_b),
    .frame_cnt(frame_cnt_b), .busy(busy_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level model: an active flag, the slot position, the phase and the
  // frame count, stepped by the rules for one clock edge.
  typedef struct packed {
    logic        act;
    logic [31:0] slot;
    logic [31:0] shift;
    logic [31:0] fc;
  } mst_t;

  function automatic mst_t mstep(input mst_t c, input int m, input int d, input int st,
                                 input logic en, input logic vld, input logic rdy);
    mst_t n = c;
    if (!c.act) begin
      if (en) begin n.act = 1'b1; n.slot = st; end
    end else if ((c.slot < d) ? (vld && rdy) : 1'b1) begin
      if (c.slot == m - 1) begin
        n.fc    = c.fc + 1;
        n.shift = (c.shift + d) % m;
        if (en) n.slot = 0;
        else begin n.act = 1'b0; n.slot = st; end
      end else begin
        n.slot = c.slot + 1;
      end
    end
    return n;
  endfunction

  mst_t ma, mb;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) ma <= '{act: 1'b0, slot: 32'd47, shift: 32'd0, fc: 32'd0};
    else       ma <= mstep(ma, 64, 48, 47, en_a, vld_a, rdy_a);
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) mb <= '{act: 1'b0, slot: 32'd0, shift: 32'd0, fc: 32'd0};
    else       mb <= mstep(mb, 16, 16, 0, en_b, vld_b, rdy_b);
  end

  // Compare process: DUT outputs against the model on every falling edge.
  // The scoreboard checks that every sample passed downstream is one the
  // model expects to pass, with none dropped and none repeated.
  always @(negedge clk) begin
    logic run_a, run_b;
    run_a = ma.act && (ma.slot < 48);
    run_b = mb.act && (mb.slot < 16);
    chk("a_busy",   busy_a,      ma.act);
    chk("a_slot",   slot_a,      ma.slot);
    chk("a_shift",  shift_a,     ma.shift);
    chk("a_fcnt",   frame_cnt_a, ma.fc);
    chk("a_tvalid", m_tvalid_a,  vld_a && run_a);
    chk("a_tready", s_tready_a,  rdy_a && run_a);
    chk("a_tlast",  m_tlast_a,   run_a && (ma.slot == 47));
    chk("a_tdata",  m_tdata_a,   sdata_a);
    chk("b_busy",   busy_b,      mb.act);
    chk("b_slot",   slot_b,      mb.slot);
    chk("b_shift",  shift_b,     mb.shift);
    chk("b_fcnt",   frame_cnt_b, mb.fc);
    chk("b_tvalid", m_tvalid_b,  vld_b && run_b);
    chk("b_tready", s_tready_b,  rdy_b && run_b);
    chk("b_tlast",  m_tlast_b,   run_b && (mb.slot == 15));
    if (run_a && vld_a && rdy_a) exp_q.push_back(sdata_a);
    if (m_tvalid_a && rdy_a) begin
      if (exp_q.size() == 0) chk("a_sb_unexpected_xfer", 1, 0);
      else chk("a_sb_data", m_tdata_a, exp_q.pop_front());
    end
  end

  // Activity counters taken from the DUT ports, used for per-frame totals.
  int cyc_a = 0, xfer_a = 0, pause_a = 0, fx_a = 0, tlast_pos_a = 0;
  int xfer_b = 0, tlast_b = 0, fx_b = 0, tlast_pos_b = 0;
  logic [31:0] pf_a = 0, pf_b = 0;
  always @(negedge clk) begin
    cyc_a++;
    if (frame_cnt_a != pf_a) begin fx_a = 0; pf_a = frame_cnt_a; end
    if (m_tvalid_a && rdy_a) begin
      xfer_a++; fx_a++;
      if (m_tlast_a) tlast_pos_a = fx_a;
    end
    if (busy_a && slot_a >= 6'd48) pause_a++;
    if (frame_cnt_b != pf_b) begin fx_b = 0; pf_b = frame_cnt_b; end
    if (m_tvalid_b && rdy_b) begin
      xfer_b++; fx_b++;
      if (m_tlast_b) begin tlast_b++; tlast_pos_b = fx_b; end
    end
  end

  // Random sample data on both sources.
  initial begin
    sdata_a = 16'h0; sdata_b = 16'h0;
    forever begin
      @(posedge clk); #1;
      sdata_a = 16'($urandom_range(0, 65535));
      sdata_b = 16'($urandom_range(0, 65535));
    end
  end

  // Driver tasks
  int mx = 0, mp = 0, mc = 0;
  int dx, dp, dc;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    dx = xfer_a - mx; dp = pause_a - mp; dc = cyc_a - mc;
    mx = xfer_a; mp = pause_a; mc = cyc_a;
  endtask

  task automatic wait_frame(input int target, input int budget);
    for (int i = 0; i < budget && frame_cnt_a != 32'(target); i++) tick(1);
    chk("frame_wait", frame_cnt_a, target);
    snap();
  endtask

  task automatic wait_slot(input int v, input int budget);
    for (int i = 0; i < budget && slot_a != 6'(v); i++) tick(1);
    chk("slot_wait", slot_a, v);
  endtask

  initial begin
    int x0, p0;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    vld_a = 1'b1; rdy_a = 1'b1; vld_b = 1'b1; rdy_b = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_slot", slot_a, 47);
    chk("rst_shift", shift_a, 0);
    chk("rst_fcnt", frame_cnt_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_tready", s_tready_a, 0);
    chk("rst_tvalid", m_tvalid_a, 0);
    chk("rst_tlast", m_tlast_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(2);
    chk("idle_no_en", busy_a, 0);
    en_a = 1'b1; en_b = 1'b1;
    tick(1);
    chk("start_busy", busy_a, 1);
    chk("start_slot", slot_a, 47);
    chk("start_tlast", m_tlast_a, 1);

    // Free running: one pass with tlast and 16 stalls, then 48 passes and
    // 16 stalls per frame. Shift goes 48, 32, 16, 0.
    wait_frame(1, 40);
    chk("f1_shift", shift_a, 48);
    chk("f1_xfer", dx, 1);
    chk("f1_pause", dp, 16);
    chk("f1_tlast_pos", tlast_pos_a, 1);
    for (int k = 2; k <= 4; k++) begin
      wait_frame(k, 100);
      chk("fk_shift", shift_a, (48 * k) % 64);
      chk("fk_xfer", dx, 48);
      chk("fk_pause", dp, 16);
      chk("fk_cycles", dc, 64);
      chk("fk_tlast_pos", tlast_pos_a, 48);
    end

    // Sink backpressure for 5 cycles at slot 10
    wait_slot(10, 100);
    rdy_a = 1'b0;
    x0 = xfer_a; p0 = pause_a;
    tick(5);
    chk("bp_slot_hold", slot_a, 10);
    chk("bp_no_xfer", xfer_a - x0, 0);
    chk("bp_no_stall", pause_a - p0, 0);
    rdy_a = 1'b1;
    wait_frame(5, 120);
    chk("bp_xfer", dx, 48);
    chk("bp_pause", dp, 16);
    chk("bp_cycles", dc, 69);
    chk("bp_shift", shift_a, 48);

    // en dropped mid-frame: the frame finishes, then the block goes idle
    wait_slot(20, 100);
    en_a = 1'b0;
    wait_frame(6, 100);
    chk("stop_busy", busy_a, 0);
    chk("stop_slot", slot_a, 47);
    chk("stop_shift", shift_a, 32);
    chk("stop_xfer", dx, 48);
    chk("stop_cycles", dc, 64);
    tick(5);
    chk("idle_busy", busy_a, 0);
    chk("idle_shift_hold", shift_a, 32);
    chk("idle_fcnt_hold", frame_cnt_a, 6);
    en_a = 1'b1;
    tick(1);
    chk("resume_busy", busy_a, 1);
    chk("resume_slot", slot_a, 47);
    wait_frame(7, 40);
    chk("resume_shift", shift_a, 16);
    chk("resume_xfer", dx, 1);
    chk("resume_pause", dp, 16);

    // Source valid toggling every cycle
    for (int i = 0; i < 300 && frame_cnt_a != 32'd8; i++) begin
      vld_a = ~vld_a;
      tick(1);
    end
    vld_a = 1'b1;
    chk("tog_frame", frame_cnt_a, 8);
    snap();
    chk("tog_xfer", dx, 48);
    chk("tog_pause", dp, 16);
    chk("tog_tlast_pos", tlast_pos_a, 48);
    chk("tog_shift", shift_a, 0);

    // Reset pulsed while in PAUSE at slot 55
    wait_slot(55, 100);
    rst_a = 1'b1;
    #1;
    chk("mrst_busy", busy_a, 0);
    chk("mrst_slot", slot_a, 47);
    chk("mrst_fcnt", frame_cnt_a, 0);
    chk("mrst_shift", shift_a, 0);
    chk("mrst_tvalid", m_tvalid_a, 0);
    chk("mrst_tready", s_tready_a, 0);
    chk("mrst_tlast", m_tlast_a, 0);
    tick(2);
    rst_a = 1'b0;
    tick(1);
    chk("mrst_restart", busy_a, 1);
    wait_frame(1, 40);
    chk("mrst_shift1", shift_a, 48);

    // Instance B, D=M=16, ran continuously the whole time
    chk("b_frames_seen", frame_cnt_b != 0, 1);
    chk("b_shift_const", shift_b, 0);
    chk("b_tlast_per_frame", tlast_b, frame_cnt_b);
    chk("b_xfer_total", xfer_b, 16 * frame_cnt_b + slot_b);
    chk("b_tlast_pos", tlast_pos_b, 16);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
